// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types for the continuous monitoring system: control-register map,
// trace FSM encoding and common constants.
package continuous_monitoring_system_pkg;

  typedef enum logic [3:0] {
    CTRL_TRIG_START_ADDR = 4'd0,
    CTRL_TRIG_END_ADDR   = 4'd1,
    CTRL_TRIG_CFG        = 4'd2,
    CTRL_ARM             = 4'd3,
    CTRL_FORCE_STOP      = 4'd4,
    CTRL_RANGE_SEL       = 4'd5,
    CTRL_RANGE_LO        = 4'd6,
    CTRL_RANGE_HI        = 4'd7,
    CTRL_RANGE_CFG       = 4'd8,
    CTRL_TLAST_INTERVAL  = 4'd9
  } ctrl_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_TRACING = 2'd2,
    ST_STOPPED = 2'd3
  } trace_state_t;

  localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;
  localparam int unsigned TLAST_CNT_W     = 8;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace packets; reads are first-word fall-through and
// the output is forced to zero while empty.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cms_trace_capture.sv
// Instruction trace capture: start/end triggers, address-range filtering,
// timestamp deltas and drop accounting, streamed out over AXI-Stream.
module cms_trace_capture
  import continuous_monitoring_system_pkg::*;
#(
  parameter  int unsigned XLEN       = 64,
  parameter  int unsigned NUM_RANGES = 4,
  parameter  int unsigned FIFO_DEPTH = 16,
  parameter  int unsigned TS_W       = 16,
  localparam int unsigned DATA_W     = XLEN + 32 + TS_W + 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pc,
  input  logic [31:0]       instr,
  input  logic              pc_valid,
  input  ctrl_addr_t        ctrl_addr,
  input  logic [XLEN-1:0]   ctrl_wdata,
  input  logic              ctrl_we,
  output logic              M_AXIS_tvalid,
  input  logic              M_AXIS_tready,
  output logic [DATA_W-1:0] M_AXIS_tdata,
  output logic              M_AXIS_tlast,
  output logic [1:0]        state_o,
  output logic [7:0]        drop_count_o
);

  localparam int unsigned RS_W = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1;

  trace_state_t r_state, w_state_nxt;
  logic [XLEN-1:0]        r_trig_start, r_trig_end;
  logic                   r_start_en, r_end_en;
  logic [RS_W-1:0]        r_range_sel;
  logic [XLEN-1:0]        r_range_lo [NUM_RANGES];
  logic [XLEN-1:0]        r_range_hi [NUM_RANGES];
  logic [NUM_RANGES-1:0]  r_range_en, r_range_excl;
  logic [TLAST_CNT_W-1:0] r_tlast_intv, r_tlast_cnt;
  logic [TS_W-1:0]        r_ts;
  logic [7:0]             r_drop;
  logic                   r_pkt_valid, r_pkt_last;
  logic [TS_W+32+XLEN-1:0] r_pkt;

  logic w_wr_arm, w_wr_stop, w_start_hit, w_end_hit, w_in_trace, w_capture;
  logic w_has_incl, w_in_incl, w_in_excl, w_filter_pass;
  logic w_full, w_empty, w_pop, w_accept, w_drop, w_periodic, w_last;
  logic [DATA_W:0] w_fifo_dout;

  assign w_wr_arm    = ctrl_we && (ctrl_addr == CTRL_ARM) &&
                       (r_state == ST_IDLE || r_state == ST_STOPPED);
  assign w_wr_stop   = ctrl_we && (ctrl_addr == CTRL_FORCE_STOP);
  assign w_start_hit = (r_state == ST_ARMED) && pc_valid && (pc == r_trig_start);
  assign w_end_hit   = (r_state == ST_TRACING) && !w_wr_stop && r_end_en &&
                       pc_valid && (pc == r_trig_end);
  // The start-trigger instruction itself is traced; a force-stop suppresses capture.
  assign w_in_trace  = !w_wr_stop && ((r_state == ST_TRACING) || w_start_hit);
  assign w_capture   = w_in_trace && pc_valid && w_filter_pass;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_wr_stop)        w_state_nxt = ST_STOPPED;
    else if (w_wr_arm)    w_state_nxt = r_start_en ? ST_ARMED : ST_TRACING;
    else if (w_start_hit) w_state_nxt = ST_TRACING;
    else if (w_end_hit)   w_state_nxt = ST_STOPPED;
  end

  always_comb begin
    w_has_incl = 1'b0;
    w_in_incl  = 1'b0;
    w_in_excl  = 1'b0;
    for (int unsigned i = 0; i < NUM_RANGES; i++) begin
      if (r_range_en[i] && !r_range_excl[i]) begin
        w_has_incl = 1'b1;
        if (pc >= r_range_lo[i] && pc <= r_range_hi[i]) w_in_incl = 1'b1;
      end
      if (r_range_en[i] && r_range_excl[i] &&
          pc >= r_range_lo[i] && pc <= r_range_hi[i]) w_in_excl = 1'b1;
    end
    w_filter_pass = (!w_has_incl || w_in_incl) && !w_in_excl;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trig_start <= '0;
      r_trig_end   <= '1;
      r_start_en   <= 1'b0;
      r_end_en     <= 1'b0;
      r_range_sel  <= '0;
      r_range_en   <= '0;
      r_range_excl <= '0;
      r_tlast_intv <= '0;
      for (int unsigned i = 0; i < NUM_RANGES; i++) begin
        r_range_lo[i] <= '0;
        r_range_hi[i] <= '1;
      end
    end else if (ctrl_we) begin
      case (ctrl_addr)
        CTRL_TRIG_START_ADDR: r_trig_start <= ctrl_wdata;
        CTRL_TRIG_END_ADDR:   r_trig_end   <= ctrl_wdata;
        CTRL_TRIG_CFG: begin
          r_start_en <= ctrl_wdata[0];
          r_end_en   <= ctrl_wdata[1];
        end
        CTRL_RANGE_SEL:      r_range_sel  <= ctrl_wdata[RS_W-1:0];
        CTRL_TLAST_INTERVAL: r_tlast_intv <= ctrl_wdata[TLAST_CNT_W-1:0];
        CTRL_RANGE_LO, CTRL_RANGE_HI, CTRL_RANGE_CFG: begin
          for (int unsigned i = 0; i < NUM_RANGES; i++) begin
            if (r_range_sel == RS_W'(i)) begin
              if (ctrl_addr == CTRL_RANGE_LO) r_range_lo[i] <= ctrl_wdata;
              if (ctrl_addr == CTRL_RANGE_HI) r_range_hi[i] <= ctrl_wdata;
              if (ctrl_addr == CTRL_RANGE_CFG) begin
                r_range_en[i]   <= ctrl_wdata[0];
                r_range_excl[i] <= ctrl_wdata[1];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // r_ts holds cycles elapsed since the last capture (or ARM) as of this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts        <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_last  <= 1'b0;
      r_pkt       <= '0;
    end else begin
      if (w_wr_arm || w_capture) r_ts <= TS_W'(1);
      else if (r_ts != '1)       r_ts <= r_ts + 1'b1;
      r_pkt_valid <= w_capture;
      if (w_capture) begin
        r_pkt      <= {r_ts, instr, pc};
        r_pkt_last <= w_end_hit;
      end
    end
  end

  assign w_pop      = M_AXIS_tvalid && M_AXIS_tready;
  assign w_accept   = r_pkt_valid && (!w_full || w_pop);
  assign w_drop     = r_pkt_valid && w_full && !w_pop;
  assign w_periodic = (r_tlast_intv != '0) &&
                      ({1'b0, r_tlast_cnt} + 1'b1 == {1'b0, r_tlast_intv});
  assign w_last     = r_pkt_last || w_periodic;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop      <= '0;
      r_tlast_cnt <= '0;
    end else begin
      if (w_accept)                 r_drop <= '0;
      else if (w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
      if (w_wr_arm || (ctrl_we && ctrl_addr == CTRL_TLAST_INTERVAL))
        r_tlast_cnt <= '0;
      else if (w_accept && r_tlast_intv != '0)
        r_tlast_cnt <= w_last ? '0 : r_tlast_cnt + 1'b1;
    end
  end

  trace_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_data  ({w_last, r_drop, r_pkt}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign M_AXIS_tvalid = !w_empty;
  assign M_AXIS_tlast  = w_fifo_dout[DATA_W];
  assign M_AXIS_tdata  = w_fifo_dout[DATA_W-1:0];
  assign state_o       = r_state;
  assign drop_count_o  = r_drop;

endmodule

// File: tb/tb_cms_trace_capture.sv
// Directed bench for cms_trace_capture: triggers, range filter, periodic
// tlast, overflow drops, force-stop and mid-stream reset.
module tb_cms_trace_capture;
  import continuous_monitoring_system_pkg::*;

  localparam int unsigned DATA_W = 64 + 32 + 16 + 8;

  logic              clk;
  logic              rst_n;
  logic [63:0]       pc;
  logic [31:0]       instr;
  logic              pc_valid;
  ctrl_addr_t        ctrl_addr;
  logic [63:0]       ctrl_wdata;
  logic              ctrl_we;
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [1:0]        state_o;
  logic [7:0]        drop_count_o;

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W:0] q [$];

  cms_trace_capture #(
    .XLEN       (64),
    .NUM_RANGES (4),
    .FIFO_DEPTH (16),
    .TS_W       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .instr         (instr),
    .pc_valid      (pc_valid),
    .ctrl_addr     (ctrl_addr),
    .ctrl_wdata    (ctrl_wdata),
    .ctrl_we       (ctrl_we),
    .M_AXIS_tvalid (tvalid),
    .M_AXIS_tready (tready),
    .M_AXIS_tdata  (tdata),
    .M_AXIS_tlast  (tlast),
    .state_o       (state_o),
    .drop_count_o  (drop_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) q.push_back({tlast, tdata});
  end

  function automatic logic [31:0] ins(input logic [63:0] a);
    return a[31:0] ^ 32'h0000_0013;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input ctrl_addr_t a, input logic [63:0] d);
    ctrl_addr  = a;
    ctrl_wdata = d;
    ctrl_we    = 1'b1;
    tick;
    ctrl_we    = 1'b0;
  endtask

  task automatic retire(input logic [63:0] a);
    pc       = a;
    instr    = ins(a);
    pc_valid = 1'b1;
    tick;
    pc_valid = 1'b0;
  endtask

  task automatic wait_q(input string tag, input int n);
    for (int i = 0; i < 60 && q.size() < n; i++) tick;
    chk(tag, q.size(), n);
  endtask

  logic [63:0] rng_pcs [7];

  initial begin
    rst_n = 1'b0; pc = '0; instr = '0; pc_valid = 1'b0;
    ctrl_addr = CTRL_TRIG_START_ADDR; ctrl_wdata = '0; ctrl_we = 1'b0; tready = 1'b0;
    tick; tick;
    chk("rst_state", state_o, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_drop", drop_count_o, 0);
    rst_n = 1'b1;
    tick;

    // Start trigger
    tready = 1'b1;
    wr(CTRL_TRIG_START_ADDR, 64'h1000);
    wr(CTRL_TRIG_CFG, 64'h1);
    wr(CTRL_ARM, 64'h0);
    chk("armed_state", state_o, 1);
    retire(64'h0FF0);
    retire(64'h1000);
    chk("lat_tvalid_c1", tvalid, 0);
    retire(64'h1004);
    chk("lat_tvalid_c2", tvalid, 1);
    chk("start_state", state_o, 2);
    wait_q("start_count", 2);
    chk("start_pkt0", q[0], {1'b0, 8'd0, 16'd2, ins(64'h1000), 64'h1000});
    chk("start_pkt1_pc", q[1][63:0], 64'h1004);
    chk("start_pkt1_delta", q[1][111:96], 1);
    q.delete();

    // End trigger
    wr(CTRL_TRIG_END_ADDR, 64'h2000);
    wr(CTRL_TRIG_CFG, 64'h3);
    retire(64'h1500);
    retire(64'h2000);
    chk("end_state", state_o, 3);
    retire(64'h2004);
    retire(64'h1000);
    repeat (6) tick;
    wait_q("end_count", 2);
    chk("end_pkt0_pc", q[0][63:0], 64'h1500);
    chk("end_pkt0_last", q[0][DATA_W], 0);
    chk("end_pkt1_pc", q[1][63:0], 64'h2000);
    chk("end_pkt1_last", q[1][DATA_W], 1);
    q.delete();

    // Range filter: include 0x100..0x1FF, exclude 0x180..0x18F
    wr(CTRL_RANGE_SEL, 64'h0);
    wr(CTRL_RANGE_LO, 64'h100);
    wr(CTRL_RANGE_HI, 64'h1FF);
    wr(CTRL_RANGE_CFG, 64'h1);
    wr(CTRL_RANGE_SEL, 64'h1);
    wr(CTRL_RANGE_LO, 64'h180);
    wr(CTRL_RANGE_HI, 64'h18F);
    wr(CTRL_RANGE_CFG, 64'h3);
    wr(CTRL_TRIG_CFG, 64'h0);
    wr(CTRL_ARM, 64'h0);
    chk("direct_trace_state", state_o, 2);
    rng_pcs = '{64'h0FC, 64'h100, 64'h184, 64'h1FF, 64'h180, 64'h190, 64'h200};
    for (int i = 0; i < 7; i++) retire(rng_pcs[i]);
    repeat (6) tick;
    wait_q("range_count", 3);
    chk("range_pkt0_pc", q[0][63:0], 64'h100);
    chk("range_pkt0_delta", q[0][111:96], 2);
    chk("range_pkt1_pc", q[1][63:0], 64'h1FF);
    chk("range_pkt2_pc", q[2][63:0], 64'h190);
    q.delete();
    wr(CTRL_RANGE_SEL, 64'h0);
    wr(CTRL_RANGE_CFG, 64'h0);
    wr(CTRL_RANGE_SEL, 64'h1);
    wr(CTRL_RANGE_CFG, 64'h0);

    // Periodic tlast every 3rd packet
    wr(CTRL_TLAST_INTERVAL, 64'd3);
    for (int i = 0; i < 7; i++) retire(64'h3000 + 64'(4 * i));
    repeat (6) tick;
    wait_q("intv_count", 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("intv_last%0d", i), q[i][DATA_W], (i == 2 || i == 5) ? 1 : 0);
      chk($sformatf("intv_pc%0d", i), q[i][63:0], 64'h3000 + 64'(4 * i));
    end
    q.delete();
    wr(CTRL_TLAST_INTERVAL, 64'd0);

    // Overflow: 20 captures into a 16-deep FIFO with the sink stalled
    tready = 1'b0;
    for (int i = 0; i < 20; i++) retire(64'h4000 + 64'(4 * i));
    repeat (3) tick;
    chk("ovf_drop", drop_count_o, 4);
    chk("ovf_tvalid", tvalid, 1);
    chk("ovf_head_pc", tdata[63:0], 64'h4000);
    repeat (4) tick;
    chk("ovf_hold_pc", tdata[63:0], 64'h4000);
    chk("ovf_hold_last", tlast, 0);
    retire(64'h5000);
    tready = 1'b1;
    tick;
    chk("ovf_pushpop_drop", drop_count_o, 0);
    retire(64'h5004);
    wait_q("ovf_count", 18);
    chk("ovf_first_pc", q[0][63:0], 64'h4000);
    chk("ovf_last_kept_pc", q[15][63:0], 64'h403C);
    chk("ovf_carry_pc", q[16][63:0], 64'h5000);
    chk("ovf_carry_drop", q[16][119:112], 4);
    chk("ovf_after_drop", q[17][119:112], 0);

    // Force stop with a simultaneous retiring instruction
    pc = 64'h6000; instr = ins(64'h6000); pc_valid = 1'b1;
    ctrl_addr = CTRL_FORCE_STOP; ctrl_wdata = '0; ctrl_we = 1'b1;
    tick;
    pc_valid = 1'b0; ctrl_we = 1'b0;
    chk("fstop_state", state_o, 3);
    retire(64'h6004);
    repeat (6) tick;
    chk("fstop_no_pkt", q.size(), 18);

    // Reset in the middle of a stalled stream
    wr(CTRL_ARM, 64'h0);
    chk("rearm_state", state_o, 2);
    tready = 1'b0;
    for (int i = 0; i < 18; i++) retire(64'h7000 + 64'(4 * i));
    chk("pre_rst_tvalid", tvalid, 1);
    chk("pre_rst_drop", drop_count_o, 1);
    rst_n = 1'b0;
    tick;
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_state", state_o, 0);
    chk("mid_rst_drop", drop_count_o, 0);
    chk("mid_rst_tdata", tdata, 0);
    rst_n = 1'b1;
    tready = 1'b1;
    repeat (4) tick;
    chk("post_rst_tvalid", tvalid, 0);
    chk("post_rst_no_pkt", q.size(), 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cms_trace_capture.md
CMS_TRACE_CAPTURE -- requirements
Module: cms_trace_capture

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC width in bits.
REQ-002 SHALL have parameter NUM_RANGES, default 4, number of address-range filters (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, internal packet buffer depth (power of two, >=2).
REQ-004 SHALL have parameter TS_W, default 16, timestamp-delta width.
REQ-005 SHALL have ports: clk input 1 (clock); rst_n input 1 (reset, synchronous, active-low).
REQ-006 SHALL have ports: pc input XLEN; instr input 32; pc_valid input 1 (instruction retires this cycle).
REQ-007 SHALL have ports: ctrl_addr input ctrl_addr_t; ctrl_wdata input XLEN; ctrl_we input 1 (level, one write per high cycle).
REQ-008 SHALL have ports: M_AXIS_tvalid output 1; M_AXIS_tready input 1; M_AXIS_tdata output DATA_W=XLEN+32+TS_W+8; M_AXIS_tlast output 1.
REQ-009 SHALL have ports: state_o output 2 (current FSM state); drop_count_o output 8 (pending drop count).

Function
REQ-010 SHALL implement FSM IDLE(0), ARMED(1), TRACING(2), STOPPED(3).
REQ-011 SHALL move IDLE/STOPPED -> ARMED on write to ARM; -> TRACING directly if start trigger disabled.
REQ-012 SHALL move ARMED -> TRACING when pc_valid and pc==TRIG_START_ADDR; that instruction is captured.
REQ-013 SHALL move TRACING -> STOPPED when end trigger enabled, pc_valid and pc==TRIG_END_ADDR; that instruction is captured with tlast=1.
REQ-014 SHALL move any state -> STOPPED on write to FORCE_STOP; no packet generated.
REQ-015 SHALL give ctrl writes priority over trigger matches in the same cycle.
REQ-016 SHALL decode ctrl: TRIG_START_ADDR, TRIG_END_ADDR, TRIG_CFG (bit0 start_en, bit1 end_en), ARM, FORCE_STOP, RANGE_SEL, RANGE_LO, RANGE_HI, RANGE_CFG (bit0 enable, bit1 exclude), TLAST_INTERVAL; LO/HI/CFG target range RANGE_SEL; unknown addresses ignored.
REQ-017 SHALL pass filter when: no enabled include range exists, or pc in an enabled include range; and pc in no enabled exclude range (bounds inclusive, unsigned).
REQ-018 SHALL capture when state (including the trigger cycle) is TRACING, pc_valid=1, and filter passes.
REQ-019 SHALL pack tdata = {drop[7:0], delta[TS_W-1:0], instr, pc}.
REQ-020 SHALL compute delta = cycles since previous captured packet (or since ARM for the first), saturating at 2^TS_W-1.
REQ-021 SHALL register the packet one cycle, write FIFO next cycle; earliest tvalid two cycles after the capture cycle.
REQ-022 SHALL, on FIFO full at write, drop the packet and increment drop counter (saturate 255); next accepted packet carries count, counter cleared.
REQ-023 SHALL assert tlast on every TLAST_INTERVAL-th accepted packet (counter cleared on tlast) and on the end-trigger packet; interval 0 disables periodic tlast.
REQ-024 SHALL hold tdata/tlast stable while tvalid=1 and tready=0; pop on tvalid&tready; simultaneous push and pop at full is not a drop.

Reset
REQ-025 SHALL reset: state IDLE, FIFO empty, tvalid=0, tdata=0, tlast=0, drop counter 0, timestamp 0, triggers and ranges disabled, TRIG_END_ADDR/RANGE_HI all-ones, others 0.
REQ-026 SHALL discard FIFO contents and in-flight packet on reset mid-operation.

Structure
REQ-027 SHALL place ctrl_addr_t enum, WFI_INSTRUCTION and state encoding in continuous_monitoring_system_pkg.
REQ-028 SHALL use one sub-module, trace_fifo (synchronous FIFO, full/empty, parameterised width/depth).

Verification
REQ-029 Start_en=1 start=0x1000, pc 0xFF0,0x1000,0x1004 valid -> two packets, pc 0x1000, 0x1004; state TRACING.
REQ-030 End_en=1 end=0x2000, TRACING, pc 0x2000 -> packet tlast=1, state STOPPED, later pcs ignored.
REQ-031 Range0 include 0x100..0x1FF, range1 exclude 0x180..0x18F; pcs 0x0FC,0x100,0x184,0x1FF -> packets 0x100, 0x1FF only.
REQ-032 tready=0, 20 captures, FIFO_DEPTH=16 -> 16 packets stored, drop=4 in next accepted packet, then 0.
REQ-033 TLAST_INTERVAL=3, 7 packets -> tlast on packets 3 and 6.
REQ-034 rst_n low while tvalid=1 -> next cycle tvalid=0, state IDLE, drop_count_o=0.
